uart_rx_fifo: RTL and testbench

Receive-side byte buffer placed directly downstream of the UART receiver. It captures each byte the receiver presents with its one-cycle ready pulse and stores it in a circular FIFO. Bytes are offered to the consumer (command parser, CPU bus bridge) over a first-word-fall-through valid/ready handshake. Occupancy and full/empty status are exported, and a sticky overflow flag records any byte lost while the buffer was full.

---
 rtl/uart_rx_fifo_if.sv | 27 ++
 rtl/uart_rx_fifo.sv | 82 ++++++++
 tb/tb_uart_rx_fifo.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Byte-stream bundle between the UART receiver, the RX FIFO and its consumer.
// master: environment side (receiver strobe, consumer ready, overflow clear).
// slave: FIFO side (head byte, occupancy and status flags).
interface uart_rx_fifo_if #(
  parameter int addr_width = 4
);
  logic [7:0]          i_rx_byte;
  logic                i_rx_ready;
  logic [7:0]          o_data;
  logic                o_valid;
  logic                i_ready;
  logic [addr_width:0] o_count;
  logic                o_full;
  logic                o_empty;
  logic                o_overflow;
  logic                i_clr_overflow;

  modport master (
    output i_rx_byte, i_rx_ready, i_ready, i_clr_overflow,
    input  o_data, o_valid, o_count, o_full, o_empty, o_overflow
  );

  modport slave (
    input  i_rx_byte, i_rx_ready, i_ready, i_clr_overflow,
    output o_data, o_valid, o_count, o_full, o_empty, o_overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver, first-word-fall-through output.
// Latency: a strobed byte is visible at the head one cycle later; pops take effect next cycle.
// Backpressure: none upstream; a strobe at full with no pop is dropped and flagged sticky.
module uart_rx_fifo #(
  parameter int addr_width = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  uart_rx_fifo_if.slave  bus
);

  localparam int depth = 1 << addr_width;
  localparam logic [addr_width:0] depth_cnt = (addr_width + 1)'(depth);

  logic [7:0]            mem [depth];
  logic [addr_width-1:0] wr_ptr;
  logic [addr_width-1:0] rd_ptr;
  logic [addr_width:0]   count;
  logic                  overflow;

  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;

  // Status is decoded from count alone, so pointer wrap never aliases full and empty.
  assign full  = (count == depth_cnt);
  assign empty = (count == '0);

  // A pop at full frees the slot the incoming byte needs in the same cycle.
  assign pop  = ~empty & bus.i_ready;
  assign push = bus.i_rx_ready & (~full | pop);
  assign drop = bus.i_rx_ready & full & ~pop;

  // Byte storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.i_rx_byte;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at depth.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a drop coinciding with a clear keeps the flag set.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (bus.i_clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  assign bus.o_data     = mem[rd_ptr];
  assign bus.o_valid    = ~empty;
  assign bus.o_count    = count;
  assign bus.o_full     = full;
  assign bus.o_empty    = empty;
  assign bus.o_overflow = overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo against a queue-based model.
module tb_uart_rx_fifo;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic i_clk;
  logic i_rst;

  uart_rx_fifo_if #(.addr_width(AW)) bus ();

  uart_rx_fifo #(.addr_width(AW)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int checks = 0;
  int passes = 0;

  logic [7:0] q[$];
  logic       mdl_ovf = 1'b0;
  logic [7:0] got[$];
  int         max_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One clock: advance the model with the inputs in force at the edge, then compare.
  task automatic step();
    logic       p;
    logic [7:0] d;
    logic       mpop;
    logic       mfull;
    logic       mdrop;
    p = bus.o_valid & bus.i_ready;
    d = bus.o_data;
    @(posedge i_clk);
    if (p) got.push_back(d);
    if (i_rst) begin
      q.delete();
      mdl_ovf = 1'b0;
    end else begin
      mpop  = (q.size() != 0) && bus.i_ready;
      mfull = (q.size() == DEPTH);
      mdrop = bus.i_rx_ready && mfull && !mpop;
      if (mpop) void'(q.pop_front());
      if (bus.i_rx_ready && !mdrop) q.push_back(bus.i_rx_byte);
      if (mdrop) mdl_ovf = 1'b1;
      else if (bus.i_clr_overflow) mdl_ovf = 1'b0;
    end
    #1;
    chk("valid", 32'(bus.o_valid), 32'(q.size() != 0));
    chk("count", 32'(bus.o_count), 32'(q.size()));
    chk("full", 32'(bus.o_full), 32'(q.size() == DEPTH));
    chk("empty", 32'(bus.o_empty), 32'(q.size() == 0));
    chk("overflow", 32'(bus.o_overflow), 32'(mdl_ovf));
    if (q.size() != 0) chk("data", 32'(bus.o_data), 32'(q[0]));
    if (int'(bus.o_count) > max_cnt) max_cnt = int'(bus.o_count);
    i_rst              = 1'b0;
    bus.i_rx_ready     = 1'b0;
    bus.i_clr_overflow = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] b);
    bus.i_rx_byte  = b;
    bus.i_rx_ready = 1'b1;
    step();
  endtask

  initial begin
    i_rst              = 1'b1;
    bus.i_rx_byte      = 8'h00;
    bus.i_rx_ready     = 1'b0;
    bus.i_ready        = 1'b0;
    bus.i_clr_overflow = 1'b0;

    // Reset state
    step();
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_empty", 32'(bus.o_empty), 32'd1);
    chk("rst_count", 32'(bus.o_count), 32'd0);
    step();

    // Single byte
    strobe(8'hA5);
    chk("single_data", 32'(bus.o_data), 32'hA5);
    chk("single_count", 32'(bus.o_count), 32'd1);
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;
    chk("single_popped_empty", 32'(bus.o_empty), 32'd1);

    // Fill and overflow, bytes spaced 16 cycles apart
    for (int i = 0; i <= 16; i++) begin
      strobe(8'(i));
      if (i == 15) begin
        chk("fill_full", 32'(bus.o_full), 32'd1);
        chk("fill_count16", 32'(bus.o_count), 32'd16);
        chk("fill_no_ovf", 32'(bus.o_overflow), 32'd0);
      end
      if (i == 16) begin
        chk("ovf_set", 32'(bus.o_overflow), 32'd1);
        chk("ovf_count16", 32'(bus.o_count), 32'd16);
      end
      repeat (15) step();
    end
    got.delete();
    bus.i_ready = 1'b1;
    repeat (18) step();
    bus.i_ready = 1'b0;
    chk("drain1_len", 32'(got.size()), 32'd16);
    for (int i = 0; i < 16 && i < got.size(); i++) chk("drain1_byte", 32'(got[i]), 32'(i));
    bus.i_clr_overflow = 1'b1;
    step();
    chk("clr_after_drain", 32'(bus.o_overflow), 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) strobe(8'(i));
    bus.i_ready = 1'b1;
    strobe(8'h55);
    bus.i_ready = 1'b0;
    chk("pp_count16", 32'(bus.o_count), 32'd16);
    chk("pp_no_ovf", 32'(bus.o_overflow), 32'd0);
    got.delete();
    bus.i_ready = 1'b1;
    repeat (17) step();
    bus.i_ready = 1'b0;
    chk("drain2_len", 32'(got.size()), 32'd16);
    for (int i = 0; i < 15 && i < got.size(); i++) chk("drain2_byte", 32'(got[i]), 32'(i + 1));
    if (got.size() == 16) chk("drain2_last", 32'(got[15]), 32'h55);

    // Wrap-around streaming: push every 3 cycles, pop every 2 cycles
    got.delete();
    max_cnt = 0;
    begin
      int pushed = 0;
      for (int c = 0; c < 400 && got.size() < 40; c++) begin
        bus.i_ready = (c % 2 == 0);
        if (c % 3 == 0 && pushed < 40) begin
          bus.i_rx_byte  = 8'(pushed);
          bus.i_rx_ready = 1'b1;
          pushed++;
        end
        step();
      end
    end
    bus.i_ready = 1'b0;
    chk("stream_len", 32'(got.size()), 32'd40);
    for (int i = 0; i < 40 && i < got.size(); i++) chk("stream_byte", 32'(got[i]), 32'(i));
    chk("stream_max_le2", 32'(max_cnt <= 2), 32'd1);
    chk("stream_no_ovf", 32'(bus.o_overflow), 32'd0);

    // Overflow clear race
    for (int i = 0; i < 16; i++) strobe(8'(8'hC0 + i));
    strobe(8'hEE);
    chk("race_ovf_set", 32'(bus.o_overflow), 32'd1);
    bus.i_clr_overflow = 1'b1;
    step();
    chk("race_clr_alone", 32'(bus.o_overflow), 32'd0);
    bus.i_clr_overflow = 1'b1;
    strobe(8'hEF);
    chk("race_set_wins", 32'(bus.o_overflow), 32'd1);
    chk("race_count16", 32'(bus.o_count), 32'd16);

    // Reset mid-operation with a coincident strobe
    bus.i_ready = 1'b1;
    repeat (11) step();
    bus.i_ready = 1'b0;
    chk("pre_rst_count5", 32'(bus.o_count), 32'd5);
    i_rst = 1'b1;
    strobe(8'h77);
    chk("midrst_count", 32'(bus.o_count), 32'd0);
    chk("midrst_valid", 32'(bus.o_valid), 32'd0);
    chk("midrst_empty", 32'(bus.o_empty), 32'd1);
    chk("midrst_ovf", 32'(bus.o_overflow), 32'd0);
    strobe(8'h3C);
    chk("post_rst_head", 32'(bus.o_data), 32'h3C);
    bus.i_ready = 1'b1;
    step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int mode;
      mode = (c / 500) % 3;
      bus.i_rx_byte      = 8'($urandom);
      bus.i_rx_ready     = ($urandom_range(0, 9) < (mode == 0 ? 8 : (mode == 1 ? 3 : 5)));
      bus.i_ready        = ($urandom_range(0, 9) < (mode == 0 ? 3 : (mode == 1 ? 8 : 5)));
      bus.i_clr_overflow = ($urandom_range(0, 19) == 0);
      i_rst              = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
